// File: rtl/move_input_conditioner.sv
// Direction-button conditioner for the 2048 controller: sync, debounce, priority, one held request.
// Optional auto-repeat while a button stays held is built when MOVE_AUTOREPEAT_EN is defined.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    input  logic move_ack,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic move_pending
);

    localparam longint CNT_MAX = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (CNT_MAX <= DEBOUNCE_CYCLES || CNT_MAX <= REPEAT_DELAY || CNT_MAX <= REPEAT_PERIOD) begin : g_chk_w
        $error("CNT_W too narrow for the configured cycle counts");
    end

    // Bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right.
    logic [3:0] raw, sync1, sync2, stable, stable_d, press, win, dir;

    assign raw = {BtnR, BtnL, BtnD, BtnU};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic             st;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                st  <= 1'b0;
                cnt <= '0;
            end else if (sync2[g] == st) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                st  <= sync2[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stable[g] = st;
    end

    assign press = stable & ~stable_d;

    always_comb begin
        win = 4'b0000;
        if      (press[0]) win = 4'b0001;
        else if (press[1]) win = 4'b0010;
        else if (press[2]) win = 4'b0100;
        else if (press[3]) win = 4'b1000;
    end

`ifdef MOVE_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic [3:0]       held;
    logic [CNT_W-1:0] rpt;
    logic             first;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            dir   <= '0;
            held  <= '0;
            rpt   <= '0;
            first <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|win) begin
                    dir   <= win;
                    held  <= win;
                    first <= 1'b1;
                    state <= PEND;
                end
                PEND: if (move_ack) begin
                    dir   <= '0;
                    rpt   <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    // A fresh press elsewhere wins over the repeat in progress.
                    if (|win) begin
                        dir   <= win;
                        held  <= win;
                        first <= 1'b1;
                        state <= PEND;
                    end else if (!(|(stable & held))) begin
                        state <= IDLE;
                    end else if (rpt == (first ? RD_LAST : RP_LAST)) begin
                        dir   <= held;
                        first <= 1'b0;
                        state <= PEND;
                    end else begin
                        rpt <= rpt + CNT_W'(1);
                    end
                end
                default: begin
                    dir   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    typedef enum logic {IDLE, PEND} state_t;

    state_t state;

    // Presses seen while a move is pending (including the ack cycle) are dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            dir   <= '0;
        end else begin
            case (state)
                IDLE: if (|win) begin
                    dir   <= win;
                    state <= PEND;
                end
                PEND: if (move_ack) begin
                    dir   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

    assign {right, left, down, up} = dir;
    assign move_pending            = |dir;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner with DEBOUNCE_CYCLES=4: vector table, hand sequences, random vs model.
module tb_move_input_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] btn;
    logic       move_ack;
    logic       up, down, left, right, move_pending;
    logic [4:0] outs;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4),
        .CNT_W          (8)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .BtnU        (btn[0]),
        .BtnD        (btn[1]),
        .BtnL        (btn[2]),
        .BtnR        (btn[3]),
        .move_ack    (move_ack),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .move_pending(move_pending)
    );

    assign outs = {move_pending, right, left, down, up};

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's clean level flips once the last D synchronised
    // samples (raw samples delayed two edges) all disagree with it.
    logic [D:0] m_hist [4];
    logic [3:0] m_st, m_prev;
    int         m_pend;

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [4:0] model_outs(input int p);
        logic [3:0] one;
        one = 4'b0001;
        if (p < 0) return 5'b00000;
        return {1'b1, one << p};
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) m_hist[i] <= '0;
            m_st   <= '0;
            m_prev <= '0;
            m_pend <= -1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_hist[i] <= {m_hist[i][D-1:0], btn[i]};
                if (m_hist[i][D:1] == {D{~m_st[i]}}) m_st[i] <= ~m_st[i];
            end
            m_prev <= m_st;
            if (m_pend >= 0) begin
                if (move_ack) m_pend <= -1;
            end else begin
                m_pend <= first_set(m_st & ~m_prev);
            end
        end
    end

    typedef struct {
        logic [3:0] mask;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        btn      = 4'b0000;
        move_ack = 1'b0;
        Reset_n  = 1'b0;

        tbl[0] = '{4'b0001, 5'b10001};
        tbl[1] = '{4'b0010, 5'b10010};
        tbl[2] = '{4'b0100, 5'b10100};
        tbl[3] = '{4'b1000, 5'b11000};
        tbl[4] = '{4'b1010, 5'b10010};
        tbl[5] = '{4'b0110, 5'b10010};
        tbl[6] = '{4'b1100, 5'b10100};
        tbl[7] = '{4'b1111, 5'b10001};
        tbl[8] = '{4'b1001, 5'b10001};

        // Buttons held through reset: the first edge after release is the first sample.
        btn = 4'b1111;
        repeat (3) @(negedge Clk);
        check("reset_outs", outs, 5'b00000);
        Reset_n = 1'b1;
        for (int e = 0; e < D + 2; e++) begin
            @(negedge Clk);
            check("reset_hold_early", outs, 5'b00000);
        end
        @(negedge Clk);
        check("reset_hold_up", outs, 5'b10001);
        move_ack = 1'b1;
        @(negedge Clk);
        check("reset_hold_ack", outs, 5'b00000);
        move_ack = 1'b0;
        btn      = 4'b0000;
        repeat (D + 6) @(negedge Clk);

        for (int v = 0; v < 9; v++) begin
            btn = tbl[v].mask;
            repeat (D + 2) @(negedge Clk);
            check("tbl_early", outs, 5'b00000);
            @(negedge Clk);
            check("tbl_req", outs, tbl[v].exp);
            move_ack = 1'b1;
            @(negedge Clk);
            check("tbl_ack", outs, 5'b00000);
            move_ack = 1'b0;
            btn      = 4'b0000;
            repeat (D + 6) @(negedge Clk);
            check("tbl_release", outs, 5'b00000);
        end

        // Clean press of left: stays high until acked, then nothing more while held.
        btn = 4'b0100;
        repeat (D + 3) @(negedge Clk);
        check("left_rise", outs, 5'b10100);
        repeat (3) @(negedge Clk);
        check("left_stays", outs, 5'b10100);
        move_ack = 1'b1;
        @(negedge Clk);
        check("left_ack", outs, 5'b00000);
        move_ack = 1'b0;
`ifndef MOVE_AUTOREPEAT_EN
        repeat (20) @(negedge Clk);
        check("left_held_once", outs, 5'b00000);
`endif
        btn = 4'b0000;
        repeat (D + 6) @(negedge Clk);

        // Bounce on right: 2-cycle pulses never survive the debouncer.
        for (int t = 0; t < 5; t++) begin
            btn[3] = 1'b1;
            repeat (2) begin
                @(negedge Clk);
                check("bounce_quiet", outs, 5'b00000);
            end
            btn[3] = 1'b0;
            repeat (2) begin
                @(negedge Clk);
                check("bounce_quiet", outs, 5'b00000);
            end
        end
        btn[3] = 1'b1;
        repeat (D + 2) @(negedge Clk);
        check("bounce_early", outs, 5'b00000);
        @(negedge Clk);
        check("bounce_right", outs, 5'b11000);
        move_ack = 1'b1;
        @(negedge Clk);
        move_ack = 1'b0;
        btn      = 4'b0000;
        repeat (D + 6) @(negedge Clk);

        // Down and right together, then up pressed while down is pending.
        btn = 4'b1010;
        repeat (D + 3) @(negedge Clk);
        check("prio_down", outs, 5'b10010);
        btn[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge Clk);
            check("drop_up_pending", outs, 5'b10010);
        end
        move_ack = 1'b1;
        @(negedge Clk);
        check("drop_ack", outs, 5'b00000);
        move_ack = 1'b0;
`ifndef MOVE_AUTOREPEAT_EN
        repeat (10) @(negedge Clk);
        check("drop_up_never", outs, 5'b00000);
`endif
        btn = 4'b0000;
        repeat (D + 6) @(negedge Clk);

        // Asynchronous reset while left is pending clears outputs before any edge.
        btn = 4'b0100;
        repeat (D + 3) @(negedge Clk);
        check("areset_pend", outs, 5'b10100);
        #2 Reset_n = 1'b0;
        #1 check("areset_immediate", outs, 5'b00000);
        btn = 4'b0000;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (D + 6) @(negedge Clk);
        check("areset_after", outs, 5'b00000);

`ifdef MOVE_AUTOREPEAT_EN
        btn[0] = 1'b1;
        repeat (D + 3) @(negedge Clk);
        check("rep_first", outs, 5'b10001);
        for (int r = 0; r < 3; r++) begin
            move_ack = 1'b1;
            @(negedge Clk);
            move_ack = 1'b0;
            check("rep_ack", outs, 5'b00000);
            repeat ((r == 0 ? 8 : 4) - 1) @(negedge Clk);
            check("rep_gap", outs, 5'b00000);
            @(negedge Clk);
            check("rep_req", outs, 5'b10001);
        end
        btn = 4'b0000;
        repeat (D + 4) @(negedge Clk);
        move_ack = 1'b1;
        @(negedge Clk);
        move_ack = 1'b0;
        repeat (20) @(negedge Clk);
        check("rep_release", outs, 5'b00000);
`else
        // Random buttons and acks against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            check("random", outs, model_outs(m_pend));
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
            move_ack = ($urandom_range(0, 3) == 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
